// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Brief    : Shared types and defaults for the scratch-memory access controller.
// Revision : 1.0
// ============================================================================
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic owner_t;
  localparam owner_t OWN_A = 1'b0;
  localparam owner_t OWN_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin picker; the last-grant flop lives in the parent.
// Revision : 1.0
// ============================================================================
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    grant_o = 2'b00;
    if (req_i[0] && (!req_i[1] || (last_i == OWN_B))) begin
      grant_o[0] = 1'b1;
    end else if (req_i[1]) begin
      grant_o[1] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Round-robin sequencer serialising A/B accesses to a single-port memory.
// Revision : 1.0
// ============================================================================
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state_q,   state_d;
  owner_t            last_q,    last_d;
  owner_t            owner_q,   owner_d;
  logic              we_q,      we_d;
  logic              mem_we_q,  mem_we_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic              a_done_q,  a_done_d;
  logic              b_done_q,  b_done_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic [1:0]        w_grant;
  logic [DATA_W-1:0] w_rd;

  rr_arb2 u_arb (
    .req_i   ({b_req, a_req}),
    .last_i  (last_q),
    .grant_o (w_grant)
  );

  assign a_gnt = w_grant[0] & (state_q == IDLE) & ~rst;
  assign b_gnt = w_grant[1] & (state_q == IDLE) & ~rst;

  // The memory floats its output during a write; never let that reach rdata.
  assign w_rd = we_q ? '0 : mem_data_out;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_we_d  = 1'b0;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    a_rdata_d = '0;
    b_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (a_gnt || b_gnt) begin
          state_d  = ACCESS;
          owner_d  = b_gnt ? OWN_B : OWN_A;
          last_d   = b_gnt ? OWN_B : OWN_A;
          we_d     = b_gnt ? b_we    : a_we;
          addr_d   = b_gnt ? b_addr  : a_addr;
          wdata_d  = b_gnt ? b_wdata : a_wdata;
          mem_we_d = b_gnt ? b_we    : a_we;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (owner_q == OWN_A) begin
          a_done_d  = 1'b1;
          a_rdata_d = w_rd;
        end else begin
          b_done_d  = 1'b1;
          b_rdata_d = w_rd;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= OWN_B;
      owner_q   <= OWN_A;
      we_q      <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      mem_we_q  <= mem_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign a_done      = a_done_q;
  assign b_done      = b_done_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;

endmodule
`default_nettype wire
